// File: rtl/symbol_text_sched_pkg.sv
// rtl/symbol_text_sched_pkg.sv - symbol codes, ASCII constants, FSM states and translation table for symbol_text_sched
package symbol_text_sched_pkg;

  localparam int P_SYMBOL_CODE_WIDTH = 7;
  localparam int P_DEFAULT_COLS      = 40;
  localparam int P_DEFAULT_ROWS      = 15;

  // Symbol codes: 0..9 digits, 10..35 letters, then punctuation, then ENTER.
  localparam logic [7:0] SYM_DIGIT_0  = 8'd0;
  localparam logic [7:0] SYM_LETTER_A = 8'd10;
  localparam logic [7:0] SYM_PLUS     = 8'd36;
  localparam logic [7:0] SYM_MINUS    = 8'd37;
  localparam logic [7:0] SYM_MUL      = 8'd38;
  localparam logic [7:0] SYM_DIV      = 8'd39;
  localparam logic [7:0] SYM_EQUAL    = 8'd40;
  localparam logic [7:0] SYM_COMMA    = 8'd41;
  localparam logic [7:0] SYM_DOT      = 8'd42;
  localparam logic [7:0] SYM_SPACE    = 8'd43;
  localparam logic [7:0] SYM_DQUOTE   = 8'd44;
  localparam logic [7:0] SYM_SQUOTE   = 8'd45;
  localparam logic [7:0] SYM_ENTER    = 8'd46;

  localparam logic [7:0] P_ASCII_DIGIT_0 = 8'h30;
  localparam logic [7:0] P_ASCII_A       = 8'h41;
  localparam logic [7:0] P_ASCII_PLUS    = 8'h2B;
  localparam logic [7:0] P_ASCII_MINUS   = 8'h2D;
  localparam logic [7:0] P_ASCII_MUL     = 8'h2A;
  localparam logic [7:0] P_ASCII_DIV     = 8'h2F;
  localparam logic [7:0] P_ASCII_EQUAL   = 8'h3D;
  localparam logic [7:0] P_ASCII_COMMA   = 8'h2C;
  localparam logic [7:0] P_ASCII_DOT     = 8'h2E;
  localparam logic [7:0] P_ASCII_DQUOTE  = 8'h22;
  localparam logic [7:0] P_ASCII_SQUOTE  = 8'h27;
  localparam logic [7:0] P_ASCII_SPACE   = 8'h20;
  localparam logic [7:0] P_ASCII_UNKNOWN = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  function automatic logic [7:0] symbol_to_ascii(input logic [15:0] code);
    logic [7:0] c;
    logic [7:0] ch;
    c  = code[7:0];
    ch = P_ASCII_UNKNOWN;
    if (code[15:8] == 8'd0) begin
      if (c < SYM_LETTER_A) begin
        ch = P_ASCII_DIGIT_0 + (c - SYM_DIGIT_0);
      end else if (c < SYM_PLUS) begin
        ch = P_ASCII_A + (c - SYM_LETTER_A);
      end else begin
        case (c)
          SYM_PLUS:   ch = P_ASCII_PLUS;
          SYM_MINUS:  ch = P_ASCII_MINUS;
          SYM_MUL:    ch = P_ASCII_MUL;
          SYM_DIV:    ch = P_ASCII_DIV;
          SYM_EQUAL:  ch = P_ASCII_EQUAL;
          SYM_COMMA:  ch = P_ASCII_COMMA;
          SYM_DOT:    ch = P_ASCII_DOT;
          SYM_SPACE:  ch = P_ASCII_SPACE;
          SYM_DQUOTE: ch = P_ASCII_DQUOTE;
          SYM_SQUOTE: ch = P_ASCII_SQUOTE;
          default:    ch = P_ASCII_UNKNOWN;
        endcase
      end
    end
    return ch;
  endfunction

endpackage

// File: rtl/symbol_text_sched_cursor.sv
// rtl/symbol_text_sched_cursor.sv - text_cursor: column/row counters with wrap and row-major address
module text_cursor
  import symbol_text_sched_pkg::*;
#(
  parameter int P_COLS       = P_DEFAULT_COLS,
  parameter int P_ROWS       = P_DEFAULT_ROWS,
  parameter int P_ADDR_WIDTH = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        advance_i,
  input  logic                        newline_i,
  output logic [$clog2(P_COLS)-1:0]   col_o,
  output logic [$clog2(P_ROWS)-1:0]   row_o,
  output logic                        row_end_o,
  output logic [P_ADDR_WIDTH-1:0]     addr_o,
  output logic [P_ADDR_WIDTH-1:0]     next_base_o
);

  localparam int COL_W = $clog2(P_COLS);
  localparam int ROW_W = $clog2(P_ROWS);
  localparam logic [P_ADDR_WIDTH-1:0] COLS_A = P_ADDR_WIDTH'(P_COLS);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d, row_next;

  assign row_end_o = (col_q == COL_W'(P_COLS - 1));

  always_comb begin
    row_next = (row_q == ROW_W'(P_ROWS - 1)) ? '0 : row_q + ROW_W'(1);
    col_d    = col_q;
    row_d    = row_q;
    if (newline_i || (advance_i && row_end_o)) begin
      col_d = '0;
      row_d = row_next;
    end else if (advance_i) begin
      col_d = col_q + COL_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // next_base_o is where a row blank starts once the cursor moves down.
  assign addr_o      = P_ADDR_WIDTH'(row_q) * COLS_A + P_ADDR_WIDTH'(col_q);
  assign next_base_o = P_ADDR_WIDTH'(row_next) * COLS_A;
  assign col_o       = col_q;
  assign row_o       = row_q;

endmodule

// File: rtl/symbol_text_sched.sv
// rtl/symbol_text_sched.sv - round-robin symbol writer into VGA text RAM
// Row blanking on new rows is built when SYMBOL_TEXT_SCHED_ROW_CLEAR_EN is defined.
module symbol_text_sched
  import symbol_text_sched_pkg::*;
#(
  parameter int P_SYMBOL_WIDTH = P_SYMBOL_CODE_WIDTH,
  parameter int P_COLS         = P_DEFAULT_COLS,
  parameter int P_ROWS         = P_DEFAULT_ROWS,
  parameter int P_ADDR_WIDTH   = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req0_valid_i,
  input  logic                        req1_valid_i,
  input  logic [P_SYMBOL_WIDTH-1:0]   req0_symbol_i,
  input  logic [P_SYMBOL_WIDTH-1:0]   req1_symbol_i,
  output logic                        req0_ready_o,
  output logic                        req1_ready_o,
  output logic                        wr_en_o,
  output logic [P_ADDR_WIDTH-1:0]     wr_addr_o,
  output logic [7:0]                  wr_data_o,
  output logic [$clog2(P_COLS)-1:0]   cursor_col_o,
  output logic [$clog2(P_ROWS)-1:0]   cursor_row_o,
  output logic                        busy_o
);

  state_e                    state_q;
  logic                      last_q;
  logic                      wr_en_q;
  logic [P_ADDR_WIDTH-1:0]   wr_addr_q;
  logic [7:0]                wr_data_q;

  logic                      grant0, grant1, idle, xfer;
  logic [P_SYMBOL_WIDTH-1:0] sel_sym;
  logic                      sel_enter;
  logic                      row_end;
  logic [P_ADDR_WIDTH-1:0]   cur_addr, next_base;

  // last_q holds the most recently granted port; a tie goes to the other one.
  always_comb begin
    grant0 = req0_valid_i && (!req1_valid_i || last_q);
    grant1 = req1_valid_i && (!req0_valid_i || !last_q);
  end

  assign idle         = (state_q == ST_IDLE) && !rst_i;
  assign req0_ready_o = idle && grant0;
  assign req1_ready_o = idle && grant1;
  assign xfer         = req0_ready_o || req1_ready_o;
  assign sel_sym      = grant0 ? req0_symbol_i : req1_symbol_i;
  assign sel_enter    = (sel_sym == P_SYMBOL_WIDTH'(SYM_ENTER));

  text_cursor #(
    .P_COLS       (P_COLS),
    .P_ROWS       (P_ROWS),
    .P_ADDR_WIDTH (P_ADDR_WIDTH)
  ) u_cursor (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .advance_i   (state_q == ST_WRITE),
    .newline_i   (xfer && sel_enter),
    .col_o       (cursor_col_o),
    .row_o       (cursor_row_o),
    .row_end_o   (row_end),
    .addr_o      (cur_addr),
    .next_base_o (next_base)
  );

`ifdef SYMBOL_TEXT_SCHED_ROW_CLEAR_EN
  localparam int COL_W = $clog2(P_COLS);
  logic [COL_W-1:0] clr_cnt_q;
`else
  logic unused_clear_sigs;
  assign unused_clear_sigs = row_end ^ (^next_base);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef SYMBOL_TEXT_SCHED_ROW_CLEAR_EN
      clr_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          wr_en_q <= 1'b0;
          if (xfer) begin
            last_q <= grant1;
            if (!sel_enter) begin
              state_q   <= ST_WRITE;
              wr_en_q   <= 1'b1;
              wr_addr_q <= cur_addr;
              wr_data_q <= symbol_to_ascii(16'(sel_sym));
            end
`ifdef SYMBOL_TEXT_SCHED_ROW_CLEAR_EN
            else begin
              state_q   <= ST_CLEAR;
              wr_en_q   <= 1'b1;
              wr_addr_q <= next_base;
              wr_data_q <= P_ASCII_SPACE;
              clr_cnt_q <= '0;
            end
`endif
          end
        end
        ST_WRITE: begin
          state_q <= ST_IDLE;
          wr_en_q <= 1'b0;
`ifdef SYMBOL_TEXT_SCHED_ROW_CLEAR_EN
          if (row_end) begin
            state_q   <= ST_CLEAR;
            wr_en_q   <= 1'b1;
            wr_addr_q <= next_base;
            wr_data_q <= P_ASCII_SPACE;
            clr_cnt_q <= '0;
          end
`endif
        end
`ifdef SYMBOL_TEXT_SCHED_ROW_CLEAR_EN
        ST_CLEAR: begin
          if (clr_cnt_q == COL_W'(P_COLS - 1)) begin
            state_q <= ST_IDLE;
            wr_en_q <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + COL_W'(1);
            wr_addr_q <= wr_addr_q + P_ADDR_WIDTH'(1);
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_symbol_text_sched.sv
// tb/tb_symbol_text_sched.sv - self-checking bench for symbol_text_sched with a screen-level reference model
module tb_symbol_text_sched;

  localparam int COLS      = 40;
  localparam int ROWS      = 15;
  localparam int SYM_ENTER = 46;
`ifdef SYMBOL_TEXT_SCHED_ROW_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [6:0] req0_symbol = '0, req1_symbol = '0;
  logic       req0_ready, req1_ready, wr_en, busy;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] cursor_col;
  logic [3:0] cursor_row;

  int checks = 0;
  int errors = 0;
  logic [17:0] obs_q[$];

  symbol_text_sched dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req0_valid_i  (req0_valid),
    .req1_valid_i  (req1_valid),
    .req0_symbol_i (req0_symbol),
    .req1_symbol_i (req1_symbol),
    .req0_ready_o  (req0_ready),
    .req1_ready_o  (req1_ready),
    .wr_en_o       (wr_en),
    .wr_addr_o     (wr_addr),
    .wr_data_o     (wr_data),
    .cursor_col_o  (cursor_col),
    .cursor_row_o  (cursor_row),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_en === 1'b1) obs_q.push_back({wr_addr, wr_data});

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_ascii(input int code);
    string tbl;
    tbl = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZ+-*/=,. \"'";
    if (code >= 0 && code < tbl.len()) return tbl[code];
    return 8'h3F;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
  endtask

  // Returns just after the accepting rising edge, with VALID dropped.
  task automatic send(input int port, input int code);
    int n;
    bit got;
    @(negedge clk);
    if (port == 0) begin req0_valid = 1'b1; req0_symbol = 7'(code); end
    else begin req1_valid = 1'b1; req1_symbol = 7'(code); end
    got = 1'b0;
    n = 0;
    while (!got && n < 300) begin
      #1;
      if ((port == 0 && req0_ready === 1'b1) || (port == 1 && req1_ready === 1'b1)) got = 1'b1;
      else begin @(negedge clk); n++; end
    end
    if (got) begin
      @(posedge clk);
      #1;
    end else begin
      checks++; errors++;
      $display("FAIL send_timeout port %0d code %0d not accepted within 300 cycles", port, code);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req0_symbol = 7'd1;
    req1_valid = 1'b1; req1_symbol = 7'd2;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    checks++; if (wr_addr !== 10'd0) begin errors++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b want 00", req0_ready, req1_ready); end
    checks++; if (cursor_col !== 6'd0 || cursor_row !== 4'd0) begin errors++; $display("FAIL reset_cursor got (%0d,%0d) want (0,0)", cursor_col, cursor_row); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1'b1; req0_symbol = 7'd1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready got %b%b want 10", req0_ready, req1_ready); end
    @(posedge clk); #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL single_ready_drop got %b want 0", req0_ready); end
    req0_valid = 1'b0;
    @(negedge clk);
    checks++; if (wr_en !== 1'b1 || wr_addr !== 10'd0 || wr_data !== 8'h31) begin errors++; $display("FAIL single_write got en %b addr %0d data %h want 1 0 31", wr_en, wr_addr, wr_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    @(negedge clk);
    checks++; if (cursor_col !== 6'd1 || wr_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_after got col %0d en %b busy %b want 1 0 0", cursor_col, wr_en, busy); end
  endtask

  task automatic test_arbitration();
    int grants[$];
    int n;
    do_reset();
    req0_valid = 1'b1; req0_symbol = 7'd10;
    req1_valid = 1'b1; req1_symbol = 7'd11;
    n = 0;
    while (n < 40) begin
      #1;
      if (req0_ready === 1'b1 && req1_ready === 1'b1) begin checks++; errors++; $display("FAIL arb_both_ready at iteration %0d", n); end
      if (req0_ready === 1'b1) grants.push_back(0);
      else if (req1_ready === 1'b1) grants.push_back(1);
      if (grants.size() == 4) break;
      @(negedge clk); n++;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (grants.size() != 4) begin errors++; $display("FAIL arb_grant_count got %0d want 4", grants.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (grants[i] != (i % 2)) begin errors++; $display("FAIL arb_order grant %0d got port %0d want %0d", i, grants[i], i % 2); end
    end
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("FAIL arb_write_count got %0d want 4", obs_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_q[i] !== {10'(i), (i % 2 == 0) ? 8'h41 : 8'h42}) begin errors++; $display("FAIL arb_write %0d got %h want %h", i, obs_q[i], {10'(i), (i % 2 == 0) ? 8'h41 : 8'h42}); end
    end
  endtask

  task automatic test_random();
    logic [17:0] exp_q[$];
    int mcol, mrow, code, r, n;
    bit newrow;
    do_reset();
    mcol = 0; mrow = 0;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) code = SYM_ENTER;
      else if (r == 1) code = $urandom_range(47, 127);
      else code = $urandom_range(0, 45);
      send($urandom_range(0, 1), code);
      newrow = 1'b0;
      if (code == SYM_ENTER) newrow = 1'b1;
      else begin
        exp_q.push_back({10'(mrow * COLS + mcol), model_ascii(code)});
        mcol++;
        if (mcol == COLS) newrow = 1'b1;
      end
      if (newrow) begin
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
        if (CLR) for (int k = 0; k < COLS; k++) exp_q.push_back({10'(mrow * COLS + k), 8'h20});
      end
    end
    repeat (2) @(negedge clk);
    n = 0;
    while (busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL random_drain busy still %b", busy); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random_write_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_write %0d got addr %0d data %h want addr %0d data %h", i, obs_q[i][17:8], obs_q[i][7:0], exp_q[i][17:8], exp_q[i][7:0]); end
    end
    checks++;
    if (cursor_col !== 6'(mcol) || cursor_row !== 4'(mrow)) begin errors++; $display("FAIL random_cursor got (%0d,%0d) want (%0d,%0d)", cursor_col, cursor_row, mcol, mrow); end
  endtask

  task automatic test_enter_clear();
    do_reset();
    for (int i = 0; i < 3; i++) send(0, $urandom_range(0, 45));
    send(1, SYM_ENTER);
`ifdef SYMBOL_TEXT_SCHED_ROW_CLEAR_EN
    for (int k = 0; k < COLS; k++) begin
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 10'(COLS + k) || wr_data !== 8'h20 || busy !== 1'b1 || cursor_col !== 6'd0 || cursor_row !== 4'd1) begin
        errors++;
        $display("FAIL enter_clear cycle %0d got en %b addr %0d data %h busy %b cur (%0d,%0d) want 1 %0d 20 1 (0,1)", k, wr_en, wr_addr, wr_data, busy, cursor_col, cursor_row, COLS + k);
      end
    end
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL enter_clear_end got en %b busy %b want 0 0", wr_en, busy); end
`else
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || cursor_col !== 6'd0 || cursor_row !== 4'd1) begin
      errors++;
      $display("FAIL enter_noclear got en %b busy %b cur (%0d,%0d) want 0 0 (0,1)", wr_en, busy, cursor_col, cursor_row);
    end
`endif
  endtask

  task automatic test_row_wrap();
    int code;
    do_reset();
    for (int i = 0; i < ROWS - 1; i++) send(i % 2, SYM_ENTER);
    for (int i = 0; i < COLS - 1; i++) send(0, $urandom_range(0, 45));
    code = $urandom_range(0, 45);
    send(1, code);
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 10'd599 || wr_data !== model_ascii(code)) begin errors++; $display("FAIL wrap_last_write got en %b addr %0d data %h want 1 599 %h", wr_en, wr_addr, wr_data, model_ascii(code)); end
`ifdef SYMBOL_TEXT_SCHED_ROW_CLEAR_EN
    for (int k = 0; k < COLS; k++) begin
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 10'(k) || wr_data !== 8'h20 || cursor_col !== 6'd0 || cursor_row !== 4'd0) begin
        errors++;
        $display("FAIL wrap_clear cycle %0d got en %b addr %0d data %h cur (%0d,%0d) want 1 %0d 20 (0,0)", k, wr_en, wr_addr, wr_data, cursor_col, cursor_row, k);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL wrap_clear_end got busy %b en %b want 0 0", busy, wr_en); end
`else
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_en !== 1'b0 || cursor_col !== 6'd0 || cursor_row !== 4'd0) begin
      errors++;
      $display("FAIL wrap_noclear got busy %b en %b cur (%0d,%0d) want 0 0 (0,0)", busy, wr_en, cursor_col, cursor_row);
    end
`endif
  endtask

  task automatic test_unmapped();
    do_reset();
    send(0, 7'h7F);
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_data !== 8'h3F || wr_addr !== 10'd0) begin errors++; $display("FAIL unmapped got en %b addr %0d data %h want 1 0 3f", wr_en, wr_addr, wr_data); end
    send(1, 60);
    @(negedge clk);
    checks++;
    if (wr_data !== 8'h3F || wr_addr !== 10'd1) begin errors++; $display("FAIL unmapped2 got addr %0d data %h want 1 3f", wr_addr, wr_data); end
  endtask

  task automatic test_reset_mid();
    int n0;
    do_reset();
`ifdef SYMBOL_TEXT_SCHED_ROW_CLEAR_EN
    send(0, SYM_ENTER);
    repeat (10) @(negedge clk);
    #2;
    checks++;
    if (wr_en !== 1'b1 || cursor_row !== 4'd1) begin errors++; $display("FAIL midreset_pre got en %b row %0d want 1 1", wr_en, cursor_row); end
`else
    send(0, 5);
    send(0, 6);
    @(negedge clk);
    #2;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 10'd1) begin errors++; $display("FAIL midreset_pre got en %b addr %0d want 1 1", wr_en, wr_addr); end
`endif
    rst = 1'b1;
    #1;
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || cursor_col !== 6'd0 || cursor_row !== 4'd0) begin
      errors++;
      $display("FAIL midreset_abort got en %b busy %b cur (%0d,%0d) want 0 0 (0,0)", wr_en, busy, cursor_col, cursor_row);
    end
    n0 = obs_q.size();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (obs_q.size() != n0) begin errors++; $display("FAIL midreset_no_writes got %0d extra writes want 0", obs_q.size() - n0); end
    req0_valid = 1'b1; req0_symbol = 7'd10;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b want 1", req0_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 10'd0 || wr_data !== 8'h41) begin errors++; $display("FAIL midreset_write got en %b addr %0d data %h want 1 0 41", wr_en, wr_addr, wr_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_random();
    test_enter_clear();
    test_row_wrap();
    test_unmapped();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
